qar_dma_copy: RTL and testbench
===============================

# qar_dma_copy

Word-granular memory-to-memory copy engine acting as a bus initiator on the QAR data-memory handshake (`mem_valid`/`mem_we`/`mem_addr`/`mem_wdata`/`mem_ready`/`mem_rdata`). It is the requesting end of the same interface that data-memory responders serve. The engine reads one word from the source, writes it to the destination, and repeats for a programmed length. It sits beside `qar_core` behind the data-bus arbiter and is controlled by a start/status register block.

## Interface
- `LEN_WIDTH`, default 16: width of the word-count fields.
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles `mem_valid` may stay high without `mem_ready`; 0 disables the watchdog.
- `clk`  in  1  clock, single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  level; requests a stop at the next transfer boundary.
- `src_addr`  in  32  byte address of the source; must be word-aligned.
- `dst_addr`  in  32  byte address of the destination; must be word-aligned.
- `len`  in  LEN_WIDTH  number of words to copy.
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky; cleared when the next `start` is accepted.
- `aborted`  out  1  sticky; cleared when the next `start` is accepted.
- `words_done`  out  LEN_WIDTH  count of completed writes; cleared when `start` is accepted.
- `mem_valid`, `mem_we`  out  1  request strobe and write enable.
- `mem_addr`, `mem_wdata`  out  32  request address and write data.
- `mem_ready`  in  1  transfer-complete pulse from the responder.
- `mem_rdata`  in  32  read data; valid when `mem_ready`=1.

## Operation
- **Reset values:** all outputs are 0, the state is IDLE, and internal pointers, the data buffer and the watchdog counter are 0.
- **States:** IDLE, RD, RGAP, WR, WGAP, DONE.
- **IDLE:**
  - On `start`: latch `src_addr`, `dst_addr` and `len`; clear `err`, `aborted` and `words_done`.
  - If `src_addr[1:0]`≠0 or `dst_addr[1:0]`≠0: set `err`=1 and go to DONE. No bus traffic occurs.
  - Else if `len`==0: go to DONE.
  - Else: go to RD.
  - `start` is ignored in every other state.
- **RD:**
  - Drive `mem_valid`=1, `mem_we`=0, `mem_addr`=src pointer.
  - On `mem_ready`: capture `mem_rdata` into a one-word buffer, add 4 to the src pointer, go to RGAP.
- **RGAP:**
  - `mem_valid`=0 for exactly one cycle.
  - Next state is WR, or DONE if an abort is pending.
- **WR:**
  - Drive `mem_valid`=1, `mem_we`=1, `mem_addr`=dst pointer, `mem_wdata`=buffer.
  - On `mem_ready`: add 4 to the dst pointer, increment `words_done`, decrement the remaining count, go to WGAP.
  - If the remaining count reaches 0 on this `mem_ready`, go to DONE instead of WGAP.
- **WGAP:**
  - `mem_valid`=0 for one cycle.
  - Next state is RD, or DONE if an abort is pending.
- **DONE:** `done`=1 and `mem_valid`=0 for one cycle, then IDLE.
- **Handshake rules:**
  - While `mem_valid`=1, `mem_we`, `mem_addr` and `mem_wdata` are stable.
  - `mem_valid` is never withdrawn before `mem_ready`, except on watchdog expiry.
  - At least one cycle with `mem_valid` low separates consecutive requests.
  - `mem_ready` seen while `mem_valid`=0 is ignored.
- **Abort:**
  - `abort` seen in any cycle of RD, RGAP, WR or WGAP sets abort-pending.
  - An in-flight transfer always completes; the engine stops at the next gap.
  - On stopping: `aborted`=1, DONE. A word that was read but not yet written is not counted.
- **Watchdog:**
  - The counter clears when entering RD or WR and increments on each cycle with `mem_valid`=1 and `mem_ready`=0.
  - When it reaches `TIMEOUT_CYCLES`: drop `mem_valid` on the next edge, set `err`=1, go to DONE.
  - If `mem_ready` arrives in the same cycle the counter reaches the limit, `mem_ready` wins.
- **Arithmetic:** pointers are 32-bit and wrap modulo 2^32 with no error. `words_done` never exceeds `len`.
- **Reset mid-operation:** asynchronous return to the reset values; `mem_valid` drops immediately and no `done` pulse is produced.

## Timing
- Latency L = number of cycles from the first cycle of `mem_valid` to the cycle in which `mem_ready`=1, with L≥1.
- Cycle 0 is the cycle in which `start` is sampled.
- A transfer occupies L+1 cycles with `mem_valid` high, then 1 gap cycle.
- An N-word copy at fixed L:
  - first `mem_valid` in cycle 1;
  - `done` in cycle 2N(L+2);
  - `busy` high in cycles 1..2N(L+2).
- `len`==0 or a misaligned address: `done` and `busy` in cycle 1 only.
- Outputs are registered. `done` is never asserted in the same cycle as `mem_valid`.

## Test plan
- **Fixed-latency copy:** `src`=0x00, `dst`=0x40, `len`=4, responder L=1.
  - Response: 8 requests, alternating reads (we=0) and writes (we=1), addresses 0x00,0x40,0x04,0x44,…
  - Each request is followed by one idle cycle.
  - `done` in cycle 24; `words_done`=4; destination equals source.
- **Random-latency copy:** `len`=6 with random L in 1..4, 5 iterations.
  - Response: destination words match source each iteration; `err`=0.
  - Never more than one request per `mem_valid` assertion.
- **Zero length and misalignment:**
  - `len`=0: `done` in cycle 1, `mem_valid` never high, `err`=0.
  - `src_addr`=0x02: `done` in cycle 1, `err`=1, no bus traffic.
- **Watchdog:** responder never ready, `TIMEOUT_CYCLES`=64.
  - Response: `mem_valid` high in cycles 1..64, low in cycle 65, `done` in cycle 65, `err`=1.
- **Abort:** `len`=8, L=2, `abort` pulsed during the 3rd word's read.
  - Response: the read completes and no write follows; `aborted`=1, `words_done`=2.
  - `done` one cycle after the read's `mem_ready`.
- **Busy start and reset:**
  - `start` asserted while busy: ignored, latched values unchanged.
  - `rst` asserted mid-WR: `mem_valid`=0 immediately, all outputs 0, no `done` pulse.

Source files
------------

// File: rtl/qar_dma_copy.sv
// Word-granular memory-to-memory copy engine: reads one word from the source, writes it to
// the destination, and repeats for the programmed length over the QAR data-memory handshake.
module qar_dma_copy #(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 aborted,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata
);

    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, DONE} state_t;

    state_t                state_q;
    logic [31:0]           src_q, dst_q, buf_q, addr_q;
    logic [LEN_WIDTH-1:0]  remain_q, words_q;
    logic [WD_W-1:0]       wd_q;
    logic                  abort_pend_q, busy_q, done_q, err_q, aborted_q, valid_q, we_q;
    logic                  abort_pend_d, wd_expire;

    // An abort arriving in the very cycle a decision is made still counts as pending.
    assign abort_pend_d = abort_pend_q | abort;
    assign wd_expire    = (TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            buf_q        <= '0;
            addr_q       <= '0;
            remain_q     <= '0;
            words_q      <= '0;
            wd_q         <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    abort_pend_q <= 1'b0;
                    if (start) begin
                        src_q     <= src_addr;
                        dst_q     <= dst_addr;
                        remain_q  <= len;
                        err_q     <= 1'b0;
                        aborted_q <= 1'b0;
                        words_q   <= '0;
                        busy_q    <= 1'b1;
                        if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (len == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            valid_q <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= src_addr;
                            wd_q    <= '0;
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    abort_pend_q <= abort_pend_d;
                    if (mem_ready) begin
                        buf_q   <= mem_rdata;
                        src_q   <= src_q + 32'd4;
                        valid_q <= 1'b0;
                        // The request-free DONE cycle doubles as the gap when stopping early.
                        if (abort_pend_d) begin
                            aborted_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q <= RGAP;
                        end
                    end else if (wd_expire) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                RGAP: begin
                    if (abort_pend_d) begin
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        valid_q <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= dst_q;
                        wd_q    <= '0;
                        state_q <= WR;
                    end
                end
                WR: begin
                    abort_pend_q <= abort_pend_d;
                    if (mem_ready) begin
                        dst_q    <= dst_q + 32'd4;
                        words_q  <= words_q + LEN_WIDTH'(1);
                        remain_q <= remain_q - LEN_WIDTH'(1);
                        valid_q  <= 1'b0;
                        if (remain_q == LEN_WIDTH'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (abort_pend_d) begin
                            aborted_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q <= WGAP;
                        end
                    end else if (wd_expire) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                WGAP: begin
                    if (abort_pend_d) begin
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        valid_q <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= src_q;
                        wd_q    <= '0;
                        state_q <= RD;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign aborted    = aborted_q;
    assign words_done = words_q;
    assign mem_valid  = valid_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = buf_q;

endmodule

// File: tb/tb_qar_dma_copy.sv
// Scoreboard bench for qar_dma_copy: a reference model predicts the bus request sequence and
// completion record per copy; a combined responder/monitor pops and compares as the DUT acts.
module tb_qar_dma_copy;
    localparam int LW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [31:0]   src_addr = '0, dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, err, aborted, mem_valid, mem_we;
    logic [LW-1:0] words_done;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata = '0;

    qar_dma_copy #(.LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err), .aborted(aborted), .words_done(words_done),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { int cyc; bit e; bit ab; int words; } dn_t;

    req_t        exp_req[$];
    dn_t         exp_done[$];
    int          lat_q[$];
    logic [31:0] snap[$];
    logic [31:0] mem [256];
    int checks = 0, passes = 0;
    int edge_cnt = 0, t0 = 0, done_seen = 0, done_base = 0, stab_err = 0, gap_err = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    endtask

    // Responder + monitor in one process so ready and observation order is fixed.
    initial begin
        bit   pv, phs;
        int   vcnt, cl;
        req_t hold, r;
        dn_t  dd;
        pv = 0; phs = 0; vcnt = 0; cl = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0; phs = 0; vcnt = 0; mem_ready = 1'b0;
                continue;
            end
            if (mem_valid) begin
                if (!pv) begin
                    hold.we = mem_we; hold.addr = mem_addr; hold.wdata = mem_wdata;
                    if (exp_req.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_req: got we=%0b addr=0x%0h, required no request", mem_we, mem_addr);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_we", {31'd0, mem_we}, {31'd0, r.we});
                        chk("req_addr", mem_addr, r.addr);
                        if (r.we) chk("req_wdata", mem_wdata, r.wdata);
                    end
                    cl   = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                    vcnt = 0;
                end else begin
                    if (mem_we !== hold.we || mem_addr !== hold.addr ||
                        (hold.we && mem_wdata !== hold.wdata)) stab_err++;
                    if (phs) gap_err++;
                end
                vcnt++;
                if (vcnt == cl + 1) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                    else        mem_rdata = mem[mem_addr[9:2]];
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                vcnt = 0;
                // Stray ready pulses while idle must be ignored by the engine.
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done=1, required no done");
                end else begin
                    dd = exp_done.pop_front();
                    chk("done_cycle", edge_cnt - t0, dd.cyc);
                    chk("done_err", {31'd0, err}, {31'd0, dd.e});
                    chk("done_aborted", {31'd0, aborted}, {31'd0, dd.ab});
                    chk("done_words", {16'd0, words_done}, dd.words);
                    chk("done_valid_low", {31'd0, mem_valid}, 32'd0);
                    chk("done_busy", {31'd0, busy}, 32'd1);
                end
            end
            pv  = mem_valid;
            phs = mem_valid && mem_ready;
        end
    end

    // Reference model: expected requests, latencies and completion record from the copy rules.
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int lmin, input int lmax, input int xfers, input bit ab, input bit wd);
        dn_t  dd;
        req_t r;
        int   x, l;
        snap.delete();
        for (int i = 0; i < n; i++) snap.push_back(mem[s[9:2] + 8'(i)]);
        dd.ab = ab; dd.e = 0; dd.words = 0; dd.cyc = 1;
        if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
            dd.e = 1;
        end else if (n > 0) begin
            x = wd ? 1 : ((xfers < 0) ? 2 * n : xfers);
            dd.cyc = 0;
            for (int t = 0; t < x; t++) begin
                l = wd ? 1000 : int'($urandom_range(lmax, lmin));
                lat_q.push_back(l);
                dd.cyc += l + 2;
                r.we    = (t % 2) == 1;
                r.addr  = r.we ? d + 32'(4 * (t / 2)) : s + 32'(4 * (t / 2));
                r.wdata = r.we ? snap[t / 2] : 32'd0;
                exp_req.push_back(r);
            end
            dd.words = wd ? 0 : x / 2;
            if (wd) begin dd.e = 1; dd.cyc = TO + 1; end
        end
        exp_done.push_back(dd);
        done_base = done_seen;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = LW'(n); start = 1'b1; t0 = edge_cnt;
        @(negedge clk); #1;
        start = 1'b0;
        chk("busy_cycle1", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(output int vc);
        int k;
        k = 0; vc = 0;
        while (done_seen == done_base) begin
            if (mem_valid) vc++;
            if (k >= 2000) begin
                checks++;
                $display("FAIL done_timeout: got no done in %0d cycles, required done", k);
                break;
            end
            @(negedge clk); #1;
            k++;
        end
        @(negedge clk); #1;
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("req_queue_drained", exp_req.size(), 32'd0);
    endtask

    task automatic wait_bus(input bit we, input logic [31:0] a);
        int k;
        k = 0;
        while (!(mem_valid && mem_we == we && mem_addr == a)) begin
            if (k >= 500) begin
                checks++;
                $display("FAIL wait_bus: got no request to 0x%0h, required one", a);
                break;
            end
            @(negedge clk); #1;
            k++;
        end
    endtask

    task automatic check_dst(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) chk("dst_word", mem[d[9:2] + 8'(i)], snap[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int vc, base;
        logic [31:0] s, d;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_err_abort", {30'd0, err, aborted}, 32'd0);
        chk("rst_words", {16'd0, words_done}, 32'd0);
        chk("rst_addr_data", mem_addr | mem_wdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fixed latency L=1, four words: done in cycle 24.
        issue(32'h00, 32'h40, 4, 1, 1, -1, 0, 0);
        wait_done(vc);
        check_dst(32'h40, 4);

        // Random latency 1..4, six words, five iterations.
        for (int it = 0; it < 5; it++) begin
            s = 32'(4 * $urandom_range(0, 40));
            d = 32'h200 + 32'(4 * $urandom_range(0, 40));
            issue(s, d, 6, 1, 4, -1, 0, 0);
            wait_done(vc);
            check_dst(d, 6);
        end

        // Zero length and misaligned addresses: done in cycle 1, no bus traffic.
        issue(32'h100, 32'h140, 0, 1, 1, -1, 0, 0);
        wait_done(vc);
        chk("len0_no_valid", vc, 32'd0);
        issue(32'h02, 32'h40, 4, 1, 1, -1, 0, 0);
        wait_done(vc);
        chk("missrc_no_valid", vc, 32'd0);
        issue(32'h20, 32'h41, 3, 1, 1, -1, 0, 0);
        wait_done(vc);

        // Watchdog: responder never ready.
        issue(32'h20, 32'h60, 2, 1, 1, -1, 0, 1);
        wait_done(vc);
        chk("wd_valid_cycles", vc, 32'd64);

        // Abort during the third read: five transfers, two words, done right after the read.
        issue(32'h00, 32'h300, 8, 2, 2, 5, 1, 0);
        wait_bus(1'b0, 32'h08);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        wait_done(vc);

        // A start while busy must not disturb the running copy.
        issue(32'h80, 32'hC0, 3, 2, 2, -1, 0, 0);
        repeat (4) @(negedge clk);
        src_addr = 32'h10; dst_addr = 32'h20; len = LW'(7); start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(vc);
        check_dst(32'hC0, 3);

        // Reset during the second write.
        issue(32'h00, 32'h40, 4, 3, 3, -1, 0, 0);
        wait_bus(1'b1, 32'h44);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, mem_valid}, 32'd0);
        chk("midrst_flags", {28'd0, busy, done, err, aborted}, 32'd0);
        chk("midrst_words", {16'd0, words_done}, 32'd0);
        chk("midrst_we_addr", {31'd0, mem_we} | mem_addr | mem_wdata, 32'd0);
        exp_req.delete(); exp_done.delete(); lat_q.delete();
        base = done_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("midrst_no_done", done_seen, base);
        chk("midrst_idle_busy", {31'd0, busy}, 32'd0);

        chk("handshake_stable", stab_err, 32'd0);
        chk("gap_between_reqs", gap_err, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
